instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Decode-and-issue controller for `ALURegIntegration`, the register-file/ALU datapath. It accepts one 16-bit instruction per handshake, decodes opcode, register and immediate fields, and drives every datapath control input for exactly one execute cycle. It also keeps a latched copy of the datapath flags, which supplies carry-in for add-with-carry operations.

## Interface
Parameters:
- `IDLE_REG_EN`, default `5'd17`: `regEnables` value meaning "no register written"; bit 4 set means no write.
- `RESET_PSR`, default `5'b00000`: reset value of `psr`.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  an instruction is offered on `instr`.
- `instr`  in  16  fields: `[15:12]` op, `[11:8]` Rdest, `[7:4]` exop or imm-high, `[3:0]` Rsrc or imm-low.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `flagsOutput`  in  5  datapath flags: `[0]` C, `[1]` L, `[2]` F, `[3]` Z, `[4]` N.
- `regEnables`  out  5  write-back register index; bit 4 set means no write.
- `buffAEnables`  out  5  A-operand register index.
- `buffBEnables`  out  5  B-operand register index.
- `immediate`  out  16  extended immediate.
- `regOrImmed`  out  1  B operand select: 1 = register, 0 = immediate.
- `Cin`  out  1  ALU carry-in.
- `op`  out  4  ALU opcode.
- `exop`  out  4  ALU extended opcode.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse alongside `done` when the opcode was illegal.
- `psr`  out  5  latched flags.

## Operation
State machine: `IDLE`, `EXEC`. All control outputs are registered.

- **IDLE**
  - `instr_ready`=1.
  - Controls at idle values: `regEnables`=`IDLE_REG_EN`, `buffAEnables`/`buffBEnables`=0, `immediate`=0, `regOrImmed`=0, `Cin`=0, `op`=0, `exop`=0.
  - Posedge with `instr_valid`=1: load decoded controls, go to `EXEC`.
- **EXEC**
  - `instr_ready`=0.
  - Next posedge: the datapath writes Rdest and the sequencer updates `psr` if the op sets flags.
  - Same edge: pulse `done`, drive controls back to idle values, go to `IDLE`.

Decode rules:
- **Common fields:** `op` = `instr[15:12]`; `buffAEnables` = `{1'b0, Rdest}`; `regEnables` = `{1'b0, Rdest}`.
- **R-type (op 0000):**
  - `exop` = `instr[7:4]`, `regOrImmed`=1, `buffBEnables` = `{1'b0, instr[3:0]}`.
  - exop 1011 (CMP): no write, so `regEnables[4]`=1.
- **I-type:** `exop`=0000, `regOrImmed`=0, `buffBEnables`=0.
  - ADDI 0101, ADDCI 0111, SUBI 1001, CMPI 1011, LWI 0011: `immediate` = sign-extend of `instr[7:0]`.
  - ADDUI 0110, ADDCUI 1101, ANDI 0001: `immediate` = zero-extend of `instr[7:0]`.
  - CMPI: no write, so `regEnables[4]`=1.
- **Shift (op 1000):** `exop` = `instr[7:4]`.
  - exop LSHI 1000 or RSHI 0111: `regOrImmed`=0, `immediate` = zero-extend of `instr[3:0]`.
  - exop LSH 0100, RSH 0101, ALSH 0110, ARSH 0011: `regOrImmed`=1, `buffBEnables` = Rsrc.
  - Any other exop: illegal.
- **Illegal opcodes:** 0010, 0100, 1010, 1100, 1110, 1111.
  - Controls stay at idle values, so no write occurs.
  - `done` and `illegal` pulse together at retirement.
  - `psr` is unchanged.
- **Carry-in:** `Cin` = `psr[0]` for ADDCI, ADDCUI, and R-type exop 0111 or 1101. `Cin`=0 otherwise.
- **Flag-setting ops:** opcodes 0101, 0110, 0111, 1101, 1001, 1011, and R-type with exop in that same set. At EXEC exit, `psr` <= `flagsOutput`.

## Timing
- Accept at edge k; controls are valid for cycle k to k+1; write and `psr` update at edge k+1.
- `done` is high during cycle k+1 to k+2.
- `instr_ready` returns to 1 at edge k+1. A new instruction can be accepted at edge k+2, giving throughput of 1 instruction per 2 cycles.
- `instr_valid` during `EXEC` is ignored and not consumed; the offer must be held until `instr_ready`=1.
- Reset asserted (including mid-EXEC):
  - Immediately: state `IDLE`; controls at idle values (so no write); `done`=0, `illegal`=0, `psr`=`RESET_PSR`.
  - After release, with no clock edge yet: `instr_ready`=1.
- `flagsOutput` is sampled only at the EXEC-exit edge.

## Test plan
- **Reset:** assert `reset` mid-EXEC -> outputs immediately at idle values, `regEnables`=17, `psr`=0; after release `instr_ready`=1.
- **LWI, sign extension:**
  - `instr`=16'h3F03 -> EXEC: `op`=0011, `regEnables`=15, `buffAEnables`=15, `regOrImmed`=0, `immediate`=16'h0003; `done` next cycle.
  - `instr`=16'h5FF6 (ADDI) -> `immediate`=16'hFFF6.
  - `instr`=16'h1FF0 (ANDI) -> `immediate`=16'h00F0.
- **CMPI, flags:** `instr`=16'hBFFB with `flagsOutput` forced to 5'b00010 -> `regEnables`=5'h1F, `immediate`=16'hFFFB, `psr`=5'b00010 after EXEC.
- **Carry:**
  - Set `psr[0]`=1 via ADDI with C flag forced; then `instr`=16'h7F01 -> `Cin`=1.
  - Then ANDI -> `Cin`=0 and `psr` unchanged.
- **Shifts:**
  - `instr`=16'h8F72 -> `exop`=0111, `immediate`=2, `regOrImmed`=0.
  - `instr`=16'h8F43 -> `exop`=0100, `regOrImmed`=1, `buffBEnables`=3.
  - `instr`=16'h8F13 -> `illegal`=1.
- **Handshake, illegal op:**
  - Hold `instr_valid` high with two back-to-back instructions -> accepted 2 cycles apart; the second is not consumed during EXEC.
  - `instr`=16'hF000 -> `done`=1 and `illegal`=1, `regEnables` stays 17.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: decode-and-issue controller for the register-file/ALU datapath.
// Accepts one 16-bit instruction per handshake, drives the datapath controls for
// exactly one execute cycle, then retires with a done pulse. Keeps a latched copy
// of the datapath flags (psr) that supplies carry-in for add-with-carry ops.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   instr_valid, instr    instruction offer; instr_ready accepts it in IDLE
//   flagsOutput           datapath flags {N,Z,F,L,C}, sampled at EXEC exit
//   regEnables            write-back register index (bit 4 set = no write)
//   buffAEnables/BEnables A/B operand register indices
//   immediate, regOrImmed extended immediate and B-operand select (1 = register)
//   Cin, op, exop         ALU carry-in and opcodes
//   done, illegal         retirement pulse, and illegal-opcode flag alongside it
//   psr                   latched flags
module instr_sequencer #(
   parameter logic [4:0] IDLE_REG_EN = 5'd17,
   parameter logic [4:0] RESET_PSR   = 5'b00000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic [4:0]  flagsOutput,
   output logic [4:0]  regEnables,
   output logic [4:0]  buffAEnables,
   output logic [4:0]  buffBEnables,
   output logic [15:0] immediate,
   output logic        regOrImmed,
   output logic        Cin,
   output logic [3:0]  op,
   output logic [3:0]  exop,
   output logic        done,
   output logic        illegal,
   output logic [4:0]  psr
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t      state_q;
   logic        ready_q, done_q, illegal_q, ill_pend_q, setf_q;
   logic [4:0]  regen_q, buffa_q, buffb_q, psr_q;
   logic [15:0] imm_q;
   logic        roi_q, cin_q;
   logic [3:0]  op_q, exop_q;

   // decoded controls for the instruction currently offered
   logic        ill_d, setf_d, roi_d, cin_d;
   logic [4:0]  regen_d, buffa_d, buffb_d;
   logic [15:0] imm_d;
   logic [3:0]  exop_d, fcode;

   logic [3:0] opc, rd, xf, rs;
   assign opc = instr[15:12];
   assign rd  = instr[11:8];
   assign xf  = instr[7:4];
   assign rs  = instr[3:0];

   // field decode
   always_comb begin
      ill_d   = 1'b0;
      regen_d = {1'b0, rd};
      buffa_d = {1'b0, rd};
      buffb_d = 5'd0;
      imm_d   = 16'd0;
      roi_d   = 1'b0;
      exop_d  = 4'd0;
      case (opc)
         4'b0000: begin
            exop_d  = xf;
            roi_d   = 1'b1;
            buffb_d = {1'b0, rs};
            if (xf == 4'b1011) regen_d[4] = 1'b1;
         end
         4'b0101, 4'b0111, 4'b1001, 4'b0011:
            imm_d = {{8{instr[7]}}, instr[7:0]};
         4'b1011: begin
            imm_d      = {{8{instr[7]}}, instr[7:0]};
            regen_d[4] = 1'b1;
         end
         4'b0110, 4'b1101, 4'b0001:
            imm_d = {8'd0, instr[7:0]};
         4'b1000: begin
            exop_d = xf;
            case (xf)
               4'b1000, 4'b0111: imm_d = {12'd0, rs};
               4'b0100, 4'b0101, 4'b0110, 4'b0011: begin
                  roi_d   = 1'b1;
                  buffb_d = {1'b0, rs};
               end
               default: ill_d = 1'b1;
            endcase
         end
         default: ill_d = 1'b1;
      endcase
   end

   // R-type classifies carry/flags by exop, everything else by opcode
   always_comb begin
      fcode  = (opc == 4'b0000) ? xf : opc;
      cin_d  = ((fcode == 4'b0111) || (fcode == 4'b1101)) && psr_q[0];
      setf_d = !ill_d && (fcode inside {4'b0101, 4'b0110, 4'b0111,
                                        4'b1101, 4'b1001, 4'b1011});
   end

   // sequencer state, registered controls and psr
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         ill_pend_q <= 1'b0;
         setf_q     <= 1'b0;
         psr_q      <= RESET_PSR;
         regen_q    <= IDLE_REG_EN;
         buffa_q    <= 5'd0;
         buffb_q    <= 5'd0;
         imm_q      <= 16'd0;
         roi_q      <= 1'b0;
         cin_q      <= 1'b0;
         op_q       <= 4'd0;
         exop_q     <= 4'd0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  state_q    <= EXEC;
                  ready_q    <= 1'b0;
                  ill_pend_q <= ill_d;
                  setf_q     <= setf_d;
                  // illegal instructions leave the controls idle
                  if (!ill_d) begin
                     regen_q <= regen_d;
                     buffa_q <= buffa_d;
                     buffb_q <= buffb_d;
                     imm_q   <= imm_d;
                     roi_q   <= roi_d;
                     cin_q   <= cin_d;
                     op_q    <= opc;
                     exop_q  <= exop_d;
                  end
               end
            end
            EXEC: begin
               state_q   <= IDLE;
               ready_q   <= 1'b1;
               done_q    <= 1'b1;
               illegal_q <= ill_pend_q;
               if (setf_q) psr_q <= flagsOutput;
               regen_q   <= IDLE_REG_EN;
               buffa_q   <= 5'd0;
               buffb_q   <= 5'd0;
               imm_q     <= 16'd0;
               roi_q     <= 1'b0;
               cin_q     <= 1'b0;
               op_q      <= 4'd0;
               exop_q    <= 4'd0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready  = ready_q;
   assign regEnables   = regen_q;
   assign buffAEnables = buffa_q;
   assign buffBEnables = buffb_q;
   assign immediate    = imm_q;
   assign regOrImmed   = roi_q;
   assign Cin          = cin_q;
   assign op           = op_q;
   assign exop         = exop_q;
   assign done         = done_q;
   assign illegal      = illegal_q;
   assign psr          = psr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed vector table, hand-written reset and
// handshake sequences, then randomized instructions against a reference model.
module tb_instr_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [4:0]  flagsOutput;
   logic [4:0]  regEnables, buffAEnables, buffBEnables;
   logic [15:0] immediate;
   logic        regOrImmed, Cin;
   logic [3:0]  op, exop;
   logic        done, illegal;
   logic [4:0]  psr;

   instr_sequencer dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .flagsOutput(flagsOutput),
      .regEnables(regEnables), .buffAEnables(buffAEnables), .buffBEnables(buffBEnables),
      .immediate(immediate), .regOrImmed(regOrImmed), .Cin(Cin), .op(op), .exop(exop),
      .done(done), .illegal(illegal), .psr(psr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] iw;
      logic [4:0]  flags;
      logic [4:0]  regen, buffa, buffb;
      logic [15:0] imm;
      logic        roi, cin;
      logic [3:0]  opx, exopx;
      logic        ill;
      logic [4:0]  psr_after;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   logic [4:0] m_psr;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
   endtask

   // Reference model: expected execute-cycle controls from the instruction rules.
   function automatic vec_t model(input logic [15:0] iw, input logic [4:0] fl,
                                  input logic [4:0] ps);
      vec_t v;
      logic [3:0] o, d, x, s, k;
      logic [7:0] lo;
      logic rtype, shift, regb, nowrite;
      o = iw[15:12]; d = iw[11:8]; x = iw[7:4]; s = iw[3:0]; lo = iw[7:0];
      rtype = (o == 4'd0);
      shift = (o == 4'd8);
      v.iw = iw; v.flags = fl;
      v.ill = (o inside {4'd2, 4'd4, 4'd10, 4'd12, 4'd14, 4'd15}) ||
              (shift && !(x inside {4'd8, 4'd7, 4'd4, 4'd5, 4'd6, 4'd3}));
      if (v.ill) begin
         v.regen = 5'd17; v.buffa = 5'd0; v.buffb = 5'd0; v.imm = 16'd0;
         v.roi = 1'b0; v.cin = 1'b0; v.opx = 4'd0; v.exopx = 4'd0;
         v.psr_after = ps;
      end else begin
         nowrite = (o == 4'd11) || (rtype && x == 4'd11);
         regb    = rtype || (shift && (x inside {4'd4, 4'd5, 4'd6, 4'd3}));
         v.opx   = o;
         v.buffa = {1'b0, d};
         v.regen = nowrite ? (5'd16 + {1'b0, d}) : {1'b0, d};
         v.roi   = regb;
         v.buffb = regb ? {1'b0, s} : 5'd0;
         v.exopx = (rtype || shift) ? x : 4'd0;
         if (shift && !regb)                          v.imm = {12'd0, s};
         else if (o inside {4'd5, 4'd7, 4'd9, 4'd11, 4'd3})
            v.imm = (lo >= 8'd128) ? (16'hFF00 | {8'd0, lo}) : {8'd0, lo};
         else if (o inside {4'd6, 4'd13, 4'd1})       v.imm = {8'd0, lo};
         else                                         v.imm = 16'd0;
         k = rtype ? x : (shift ? 4'd0 : o);
         v.cin = (k inside {4'd7, 4'd13}) ? ps[0] : 1'b0;
         v.psr_after = (k inside {4'd5, 4'd6, 4'd7, 4'd13, 4'd9, 4'd11}) ? fl : ps;
      end
      return v;
   endfunction

   // Offer one instruction from IDLE; check the EXEC cycle and the retire cycle.
   task automatic run_instr(input vec_t v, input logic [4:0] junk, input int idx);
      @(negedge clock);
      chk("ready_idle", idx, 32'(instr_ready), 32'd1);
      instr_valid = 1'b1; instr = v.iw; flagsOutput = junk;
      @(negedge clock);
      instr_valid = 1'b0; instr = 16'h0000; flagsOutput = v.flags;
      chk("ready_exec", idx, 32'(instr_ready), 32'd0);
      chk("done_exec", idx, 32'(done), 32'd0);
      chk("regEnables", idx, 32'(regEnables), 32'(v.regen));
      chk("buffA", idx, 32'(buffAEnables), 32'(v.buffa));
      chk("buffB", idx, 32'(buffBEnables), 32'(v.buffb));
      chk("immediate", idx, 32'(immediate), 32'(v.imm));
      chk("regOrImmed", idx, 32'(regOrImmed), 32'(v.roi));
      chk("Cin", idx, 32'(Cin), 32'(v.cin));
      chk("op", idx, 32'(op), 32'(v.opx));
      chk("exop", idx, 32'(exop), 32'(v.exopx));
      @(negedge clock);
      flagsOutput = ~v.flags;
      chk("done", idx, 32'(done), 32'd1);
      chk("illegal", idx, 32'(illegal), 32'(v.ill));
      chk("regEn_retire", idx, 32'(regEnables), 32'd17);
      chk("op_retire", idx, 32'(op), 32'd0);
      chk("ready_retire", idx, 32'(instr_ready), 32'd1);
      chk("psr", idx, 32'(psr), 32'(v.psr_after));
      m_psr = v.psr_after;
   endtask

   vec_t tbl[14];
   vec_t rv;

   initial begin
      tbl[0]  = '{16'h3F03, 5'h1F, 5'h0F, 5'h0F, 5'h00, 16'h0003, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 5'h00};
      tbl[1]  = '{16'h5FF6, 5'h01, 5'h0F, 5'h0F, 5'h00, 16'hFFF6, 1'b0, 1'b0, 4'h5, 4'h0, 1'b0, 5'h01};
      tbl[2]  = '{16'h7F01, 5'h01, 5'h0F, 5'h0F, 5'h00, 16'h0001, 1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 5'h01};
      tbl[3]  = '{16'h1FF0, 5'h10, 5'h0F, 5'h0F, 5'h00, 16'h00F0, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 5'h01};
      tbl[4]  = '{16'hBFFB, 5'h02, 5'h1F, 5'h0F, 5'h00, 16'hFFFB, 1'b0, 1'b0, 4'hB, 4'h0, 1'b0, 5'h02};
      tbl[5]  = '{16'h8F72, 5'h1F, 5'h0F, 5'h0F, 5'h00, 16'h0002, 1'b0, 1'b0, 4'h8, 4'h7, 1'b0, 5'h02};
      tbl[6]  = '{16'h8F43, 5'h1F, 5'h0F, 5'h0F, 5'h03, 16'h0000, 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 5'h02};
      tbl[7]  = '{16'h8F13, 5'h1F, 5'h11, 5'h00, 5'h00, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 5'h02};
      tbl[8]  = '{16'hF000, 5'h1F, 5'h11, 5'h00, 5'h00, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 5'h02};
      tbl[9]  = '{16'h0AB3, 5'h04, 5'h1A, 5'h0A, 5'h03, 16'h0000, 1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 5'h04};
      tbl[10] = '{16'h0C7D, 5'h05, 5'h0C, 5'h0C, 5'h0D, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h7, 1'b0, 5'h05};
      tbl[11] = '{16'h0C7D, 5'h00, 5'h0C, 5'h0C, 5'h0D, 16'h0000, 1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 5'h00};
      tbl[12] = '{16'hD280, 5'h03, 5'h02, 5'h02, 5'h00, 16'h0080, 1'b0, 1'b0, 4'hD, 4'h0, 1'b0, 5'h03};
      tbl[13] = '{16'h6180, 5'h08, 5'h01, 5'h01, 5'h00, 16'h0080, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0, 5'h08};

      reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; flagsOutput = 5'h00;
      m_psr = 5'h00;
      #1;
      chk("rst_regEn", 0, 32'(regEnables), 32'd17);
      chk("rst_psr", 0, 32'(psr), 32'd0);
      chk("rst_done", 0, 32'(done), 32'd0);
      @(negedge clock); reset = 1'b0;
      #1 chk("rst_ready", 0, 32'(instr_ready), 32'd1);

      // directed vectors, applied in order (psr carries from row to row)
      for (int i = 0; i < 14; i++) run_instr(tbl[i], ~tbl[i].flags, i);

      // reset in the middle of EXEC
      @(negedge clock);
      instr_valid = 1'b1; instr = 16'h5FF6; flagsOutput = 5'h1F;
      @(negedge clock);
      instr_valid = 1'b0;
      chk("midexec_regEn", 1, 32'(regEnables), 32'h0F);
      reset = 1'b1;
      #1;
      chk("midrst_regEn", 1, 32'(regEnables), 32'd17);
      chk("midrst_imm", 1, 32'(immediate), 32'd0);
      chk("midrst_op", 1, 32'(op), 32'd0);
      chk("midrst_done", 1, 32'(done), 32'd0);
      chk("midrst_psr", 1, 32'(psr), 32'd0);
      @(negedge clock); reset = 1'b0;
      #1 chk("midrst_ready", 1, 32'(instr_ready), 32'd1);
      @(negedge clock);
      chk("midrst_nodone", 1, 32'(done), 32'd0);
      chk("midrst_psr2", 1, 32'(psr), 32'd0);
      m_psr = 5'h00;

      // two back-to-back offers with instr_valid held high
      instr_valid = 1'b1; instr = 16'h3103; flagsOutput = 5'h00;
      @(negedge clock);
      chk("hs_a_regEn", 2, 32'(regEnables), 32'h01);
      chk("hs_a_ready", 2, 32'(instr_ready), 32'd0);
      instr = 16'h3204;
      @(negedge clock);
      chk("hs_a_done", 2, 32'(done), 32'd1);
      chk("hs_b_notyet", 2, 32'(regEnables), 32'd17);
      chk("hs_ready_back", 2, 32'(instr_ready), 32'd1);
      @(negedge clock);
      instr_valid = 1'b0;
      chk("hs_b_regEn", 2, 32'(regEnables), 32'h02);
      chk("hs_b_imm", 2, 32'(immediate), 32'h0004);
      chk("hs_b_done_low", 2, 32'(done), 32'd0);
      @(negedge clock);
      chk("hs_b_done", 2, 32'(done), 32'd1);
      @(negedge clock);
      chk("hs_idle_done", 2, 32'(done), 32'd0);

      // randomized instructions against the model
      for (int i = 0; i < 200; i++) begin
         rv = model(16'($urandom), 5'($urandom), m_psr);
         run_instr(rv, 5'($urandom), 100 + i);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(negedge clock);
            chk("gap_done", 100 + i, 32'(done), 32'd0);
            chk("gap_psr", 100 + i, 32'(psr), 32'(m_psr));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
